// File: rtl/sifh_peak_scan_pkg.sv
// Shared sizing defaults, RAM read latency and FSM state encoding for the SiFH peak scanner.
package sifh_peak_scan_pkg;

  localparam int SIFH_NB  = 4;
  localparam int SIFH_PIX = 2;
  localparam int SIFH_AW  = 5;
  localparam int SIFH_CW  = 8;
  localparam int SIFH_PW  = 8;

  localparam int SIFH_RAM_RD_LAT = 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    DRAIN = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/sifh_argmax_acc.sv
// Running argmax register: the first word of a pixel loads unconditionally, later words
// replace it only when strictly greater so ties keep the lowest bin.
module sifh_argmax_acc #(
  parameter int NB = 4,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          res,
  input  logic          first,
  input  logic          vld,
  input  logic [CW-1:0] data,
  input  logic [NB-1:0] idx,
  output logic [CW-1:0] max,
  output logic [NB-1:0] arg
);

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      max <= '0;
      arg <= '0;
    end else if (vld && (first || data > max)) begin
      max <= data;
      arg <= idx;
    end
  end

endmodule

// File: rtl/sifh_peak_scan.sv
// Scans each pixel's histogram bins from RAM, reports the peak bin per pixel over a
// valid/ready stream and optionally zeroes every bin once its data has come back.
//
// state | meaning
// IDLE  | waiting for start
// SCAN  | issuing one bin read per cycle for the current pixel
// DRAIN | last bin's data in flight
// EMIT  | result held on pk_* until accepted
// DONE  | one-cycle done pulse
module sifh_peak_scan
  import sifh_peak_scan_pkg::*;
#(
  parameter int NB  = SIFH_NB,
  parameter int PIX = SIFH_PIX,
  parameter int AW  = SIFH_AW,
  parameter int CW  = SIFH_CW,
  parameter int PW  = SIFH_PW
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          clear_en,
  input  logic [CW-1:0] thresh,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ram_raddr,
  output logic          ram_ren,
  input  logic [CW-1:0] ram_rdata,
  output logic [AW-1:0] ram_waddr,
  output logic          ram_wen,
  output logic          pk_valid,
  input  logic          pk_ready,
  output logic [PW-1:0] pk_pixel,
  output logic [NB-1:0] pk_bin,
  output logic [CW-1:0] pk_count,
  output logic          pk_hit
);

  localparam int LAT = SIFH_RAM_RD_LAT;

  state_t        state;
  logic          clear_q;
  logic [CW-1:0] thresh_q;
  logic [PW-1:0] pixel;
  logic          last_bin;

  logic [LAT-1:0] vld_pipe;
  logic [AW-1:0]  addr_pipe [LAT];
  logic           rd_vld;
  logic [AW-1:0]  rd_addr;
  logic           rd_first;
  logic [CW-1:0]  max_q;
  logic [NB-1:0]  arg_q;

  // Pixel bases are BINS-aligned, so the low NB address bits are the bin index.
  assign last_bin = (ram_raddr[NB-1:0] == {NB{1'b1}});

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      clear_q   <= 1'b0;
      thresh_q  <= '0;
      pixel     <= '0;
      ram_raddr <= '0;
      ram_ren   <= 1'b0;
      pk_valid  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            busy      <= 1'b1;
            clear_q   <= clear_en;
            thresh_q  <= thresh;
            pixel     <= '0;
            ram_raddr <= '0;
            ram_ren   <= 1'b1;
          end
        end
        SCAN: begin
          if (last_bin) begin
            state   <= DRAIN;
            ram_ren <= 1'b0;
          end else begin
            ram_raddr <= ram_raddr + 1'b1;
          end
        end
        DRAIN: begin
          state    <= EMIT;
          pk_valid <= 1'b1;
        end
        EMIT: begin
          if (pk_ready) begin
            pk_valid <= 1'b0;
            if (pixel == PW'(PIX - 1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state     <= SCAN;
              pixel     <= pixel + 1'b1;
              ram_raddr <= ram_raddr + 1'b1;
              ram_ren   <= 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      vld_pipe <= '0;
      for (int i = 0; i < LAT; i++) addr_pipe[i] <= '0;
    end else begin
      vld_pipe[0]  <= ram_ren;
      addr_pipe[0] <= ram_raddr;
      for (int i = 1; i < LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        addr_pipe[i] <= addr_pipe[i-1];
      end
    end
  end

  assign rd_vld   = vld_pipe[LAT-1];
  assign rd_addr  = addr_pipe[LAT-1];
  assign rd_first = rd_vld && (rd_addr[NB-1:0] == '0);

  // Clearing on data arrival guarantees the zero-write always follows its own read.
  assign ram_wen   = rd_vld & clear_q;
  assign ram_waddr = rd_addr;

  sifh_argmax_acc #(
    .NB (NB),
    .CW (CW)
  ) u_acc (
    .clk   (clk),
    .res   (res),
    .first (rd_first),
    .vld   (rd_vld),
    .data  (ram_rdata),
    .idx   (rd_addr[NB-1:0]),
    .max   (max_q),
    .arg   (arg_q)
  );

  assign pk_pixel = pk_valid ? pixel : '0;
  assign pk_bin   = pk_valid ? arg_q : '0;
  assign pk_count = pk_valid ? max_q : '0;
  assign pk_hit   = pk_valid && (max_q >= thresh_q);

endmodule

// File: tb/tb_sifh_peak_scan.sv
// Self-checking bench for sifh_peak_scan: behavioural read-first RAM, argmax reference
// model over the loaded histogram image, and one task per scenario.
module tb_sifh_peak_scan;

  localparam int NB = 4, PIX = 2, AW = 5, CW = 8, PW = 8;
  localparam int BINS = 16, WORDS = 32;

  logic          clk = 1'b0;
  logic          res = 1'b0;
  logic          start = 1'b0;
  logic          clear_en = 1'b0;
  logic [CW-1:0] thresh = '0;
  logic          pk_ready = 1'b0;
  logic          busy, done, ram_ren, ram_wen, pk_valid, pk_hit;
  logic [AW-1:0] ram_raddr, ram_waddr;
  logic [CW-1:0] ram_rdata = '0;
  logic [PW-1:0] pk_pixel;
  logic [NB-1:0] pk_bin;
  logic [CW-1:0] pk_count;

  always #5 clk = ~clk;

  sifh_peak_scan #(.NB(NB), .PIX(PIX), .AW(AW), .CW(CW), .PW(PW)) dut (
    .clk(clk), .res(res), .start(start), .clear_en(clear_en), .thresh(thresh),
    .busy(busy), .done(done), .ram_raddr(ram_raddr), .ram_ren(ram_ren),
    .ram_rdata(ram_rdata), .ram_waddr(ram_waddr), .ram_wen(ram_wen),
    .pk_valid(pk_valid), .pk_ready(pk_ready), .pk_pixel(pk_pixel), .pk_bin(pk_bin),
    .pk_count(pk_count), .pk_hit(pk_hit)
  );

  typedef struct packed {
    logic [7:0] pix;
    logic [3:0] bin;
    logic [7:0] cnt;
    logic       hit;
  } res_t;

  logic [7:0] mem [WORDS];
  logic [7:0] img [WORDS];
  logic [7:0] rd_tmp;
  int         rd_seen [WORDS];
  int         wr_cnt [WORDS];
  int         order_err, ren_cnt, wen_cnt, done_cnt;
  res_t       got [$];
  res_t       exp_res [PIX];
  int         checks_total = 0;
  int         checks_passed = 0;

  // Read-first dual-port RAM, one cycle read latency.
  always @(posedge clk) begin
    if (ram_ren) rd_tmp = mem[ram_raddr];
    if (ram_wen) mem[ram_waddr] = 8'd0;
    if (ram_ren) ram_rdata <= rd_tmp;
  end

  always @(negedge clk) begin
    if (ram_wen) begin
      wr_cnt[ram_waddr]++;
      if (rd_seen[ram_waddr] == 0) order_err++;
      wen_cnt++;
    end
    if (ram_ren) begin
      rd_seen[ram_raddr] = 1;
      ren_cnt++;
    end
    if (done) done_cnt++;
    if (pk_valid && pk_ready) got.push_back('{pk_pixel, pk_bin, pk_count, pk_hit});
  end

  // Reference: per pixel, the highest count wins; the lowest bin wins a tie.
  function automatic void model(input logic [7:0] th);
    for (int p = 0; p < PIX; p++) begin
      logic [7:0] best;
      logic [3:0] bb;
      best = img[p*BINS];
      bb = 4'd0;
      for (int b = 1; b < BINS; b++)
        if (img[p*BINS+b] > best) begin
          best = img[p*BINS+b];
          bb = 4'(b);
        end
      exp_res[p] = '{8'(p), bb, best, (best >= th)};
    end
  endfunction

  task automatic load_img();
    for (int i = 0; i < WORDS; i++) mem[i] = img[i];
  endtask

  task automatic clear_mon();
    for (int i = 0; i < WORDS; i++) begin
      rd_seen[i] = 0;
      wr_cnt[i] = 0;
    end
    order_err = 0; ren_cnt = 0; wen_cnt = 0; done_cnt = 0;
    got.delete();
  endtask

  task automatic run_scan(input bit clr, input logic [7:0] th, input bit rnd, output int cyc);
    @(posedge clk); #1;
    start = 1'b1; clear_en = clr; thresh = th;
    pk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clear_en = 1'($urandom_range(0, 1)); thresh = 8'($urandom);
    if (rnd) pk_ready = 1'($urandom_range(0, 1));
    cyc = 1;
    while (!done && cyc < 3000) begin
      @(posedge clk); #1;
      cyc++;
      if (rnd) pk_ready = 1'($urandom_range(0, 1));
    end
    if (!done) cyc = -1;
    @(posedge clk); #1;
    pk_ready = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks_total++;
    if ({busy, done, ram_ren, ram_wen, pk_valid, pk_hit, ram_raddr, ram_waddr,
         pk_pixel, pk_bin, pk_count} !== '0)
      $display("FAIL reset_outputs busy=%b done=%b ren=%b wen=%b valid=%b raddr=%0d count=%0d, all must be 0",
               busy, done, ram_ren, ram_wen, pk_valid, ram_raddr, pk_count);
    else checks_passed++;
    res = 1'b1;
    @(posedge clk); #1;
    checks_total++;
    if ({busy, ram_ren, pk_valid} !== 3'b000)
      $display("FAIL idle_after_reset busy=%b ren=%b valid=%b, required 000", busy, ram_ren, pk_valid);
    else checks_passed++;
  endtask

  task automatic test_basic();
    int cyc;
    for (int i = 0; i < WORDS; i++) img[i] = (i < BINS) ? 8'd1 : 8'd0;
    img[5] = 8'd9;
    load_img(); clear_mon(); model(8'd3);
    run_scan(1'b0, 8'd3, 1'b0, cyc);
    checks_total++;
    if (cyc !== 37) $display("FAIL basic_latency got %0d cycles, required 37", cyc);
    else checks_passed++;
    checks_total++;
    if (exp_res[0] !== res_t'({8'd0, 4'd5, 8'd9, 1'b1}) || exp_res[1] !== res_t'({8'd1, 4'd0, 8'd0, 1'b0}))
      $display("FAIL basic_model got %h %h, required 00_5_09_1 01_0_00_0", exp_res[0], exp_res[1]);
    else checks_passed++;
    checks_total++;
    if (got.size() !== PIX) $display("FAIL basic_count got %0d results, required %0d", got.size(), PIX);
    else checks_passed++;
    for (int p = 0; p < PIX; p++) begin
      res_t g;
      g = (p < got.size()) ? got[p] : '1;
      checks_total++;
      if (g !== exp_res[p]) $display("FAIL basic_result[%0d] got %h, required %h", p, g, exp_res[p]);
      else checks_passed++;
    end
    checks_total++;
    if (done_cnt !== 1 || wen_cnt !== 0)
      $display("FAIL basic_done_wen got done=%0d wen=%0d, required 1 and 0", done_cnt, wen_cnt);
    else checks_passed++;
  endtask

  task automatic test_tie();
    int cyc;
    logic [7:0] th;
    for (int i = 0; i < WORDS; i++) img[i] = (i < BINS) ? 8'd2 : 8'($urandom_range(0, 5));
    img[3] = 8'd7;
    img[11] = 8'd7;
    th = 8'($urandom_range(0, 9));
    load_img(); clear_mon(); model(th);
    run_scan(1'b0, th, 1'b0, cyc);
    checks_total++;
    if (got.size() !== PIX) $display("FAIL tie_count got %0d results, required %0d", got.size(), PIX);
    else checks_passed++;
    for (int p = 0; p < PIX; p++) begin
      res_t g;
      g = (p < got.size()) ? got[p] : '1;
      checks_total++;
      if (g !== exp_res[p]) $display("FAIL tie_result[%0d] got %h, required %h", p, g, exp_res[p]);
      else checks_passed++;
    end
    checks_total++;
    if (got.size() > 0 && (got[0].bin !== 4'd3 || got[0].cnt !== 8'd7))
      $display("FAIL tie_bin got bin=%0d count=%0d, required bin=3 count=7", got[0].bin, got[0].cnt);
    else checks_passed++;
  endtask

  task automatic test_clear();
    int cyc, bad, nonzero;
    for (int i = 0; i < WORDS; i++) img[i] = 8'($urandom_range(1, 255));
    load_img(); clear_mon(); model(8'd100);
    run_scan(1'b1, 8'd100, 1'b0, cyc);
    for (int p = 0; p < PIX; p++) begin
      res_t g;
      g = (p < got.size()) ? got[p] : '1;
      checks_total++;
      if (g !== exp_res[p]) $display("FAIL clear_result[%0d] got %h, required %h", p, g, exp_res[p]);
      else checks_passed++;
    end
    bad = 0;
    nonzero = 0;
    for (int i = 0; i < WORDS; i++) begin
      if (wr_cnt[i] != 1) bad++;
      if (mem[i] != 8'd0) nonzero++;
    end
    checks_total++;
    if (bad != 0) $display("FAIL clear_writes got %0d addresses not written exactly once, required 0", bad);
    else checks_passed++;
    checks_total++;
    if (order_err != 0) $display("FAIL clear_order got %0d writes before read, required 0", order_err);
    else checks_passed++;
    checks_total++;
    if (nonzero != 0) $display("FAIL clear_ram got %0d nonzero words, required 0", nonzero);
    else checks_passed++;
    for (int i = 0; i < WORDS; i++) img[i] = 8'd0;
    clear_mon(); model(8'd0);
    run_scan(1'b0, 8'd0, 1'b0, cyc);
    checks_total++;
    if (got.size() !== PIX) $display("FAIL clear_rescan_count got %0d results, required %0d", got.size(), PIX);
    else checks_passed++;
    for (int p = 0; p < PIX; p++) begin
      res_t g;
      g = (p < got.size()) ? got[p] : '1;
      checks_total++;
      if (g !== exp_res[p]) $display("FAIL clear_rescan[%0d] got %h, required %h", p, g, exp_res[p]);
      else checks_passed++;
    end
  endtask

  task automatic test_back_pressure();
    int n, r0, w0, unstable;
    logic [20:0] snap;
    for (int i = 0; i < WORDS; i++) img[i] = (i < BINS) ? 8'd1 : 8'd0;
    img[5] = 8'd9;
    load_img(); clear_mon(); model(8'd3);
    pk_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; clear_en = 1'b1; thresh = 8'd3;
    @(posedge clk); #1;
    start = 1'b0; clear_en = 1'b0; thresh = 8'd200;
    n = 0;
    while (!pk_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    snap = {pk_pixel, pk_bin, pk_count, pk_hit};
    checks_total++;
    if (snap !== exp_res[0] || !pk_valid)
      $display("FAIL bp_first got valid=%b %h, required 1 %h", pk_valid, snap, exp_res[0]);
    else checks_passed++;
    r0 = ren_cnt;
    w0 = wen_cnt;
    unstable = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if ({pk_valid, pk_pixel, pk_bin, pk_count, pk_hit} !== {1'b1, snap}) unstable++;
    end
    checks_total++;
    if (unstable != 0) $display("FAIL bp_stable got %0d changed cycles, required 0", unstable);
    else checks_passed++;
    checks_total++;
    if (ren_cnt != r0 || wen_cnt != w0)
      $display("FAIL bp_quiet got %0d reads %0d writes while stalled, required 0 0", ren_cnt - r0, wen_cnt - w0);
    else checks_passed++;
    pk_ready = 1'b1;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks_total++;
    if (!done) $display("FAIL bp_done got no done within %0d cycles, required done", n);
    else checks_passed++;
    @(posedge clk); #1;
    pk_ready = 1'b0;
    checks_total++;
    if (got.size() !== PIX || got[0] !== exp_res[0] || got[1] !== exp_res[1])
      $display("FAIL bp_results got %0d results, required %h %h", got.size(), exp_res[0], exp_res[1]);
    else checks_passed++;
  endtask

  task automatic test_start_ignored();
    int n;
    for (int i = 0; i < WORDS; i++) img[i] = 8'($urandom_range(0, 254));
    img[15] = 8'd255;
    load_img(); clear_mon(); model(8'd50);
    pk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; thresh = 8'd50; clear_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (60) @(posedge clk);
    #1;
    checks_total++;
    if (done_cnt != 1 || busy !== 1'b0)
      $display("FAIL restart_ignored got done=%0d busy=%b, required 1 and 0", done_cnt, busy);
    else checks_passed++;
    checks_total++;
    if (got.size() !== PIX || got[0] !== exp_res[0] || got[1] !== exp_res[1])
      $display("FAIL restart_results got %0d results, required %h %h", got.size(), exp_res[0], exp_res[1]);
    else checks_passed++;
    checks_total++;
    if (got.size() > 0 && (got[0].bin !== 4'd15 || got[0].cnt !== 8'd255))
      $display("FAIL max_bin got bin=%0d count=%0d, required 15 255", got[0].bin, got[0].cnt);
    else checks_passed++;
    pk_ready = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    int n, cyc;
    for (int i = 0; i < WORDS; i++) img[i] = 8'($urandom_range(0, 255));
    load_img(); clear_mon(); model(8'd128);
    pk_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; thresh = 8'd128; clear_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!(ram_ren && ram_raddr >= 5'd20) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks_total++;
    if (!(ram_ren && ram_raddr >= 5'd20)) $display("FAIL midreset_reach got raddr=%0d ren=%b, required >=20 and 1", ram_raddr, ram_ren);
    else checks_passed++;
    res = 1'b0;
    #1;
    checks_total++;
    if ({busy, done, ram_ren, ram_wen, pk_valid, pk_hit, ram_raddr, ram_waddr,
         pk_pixel, pk_bin, pk_count} !== '0)
      $display("FAIL midreset_outputs busy=%b ren=%b raddr=%0d waddr=%0d valid=%b, all must be 0",
               busy, ram_ren, ram_raddr, ram_waddr, pk_valid);
    else checks_passed++;
    #3 res = 1'b1;
    load_img(); clear_mon();
    run_scan(1'b0, 8'd128, 1'b0, cyc);
    checks_total++;
    if (cyc !== 37) $display("FAIL midreset_latency got %0d cycles, required 37", cyc);
    else checks_passed++;
    for (int p = 0; p < PIX; p++) begin
      res_t g;
      g = (p < got.size()) ? got[p] : '1;
      checks_total++;
      if (g !== exp_res[p]) $display("FAIL midreset_result[%0d] got %h, required %h", p, g, exp_res[p]);
      else checks_passed++;
    end
  endtask

  task automatic test_random();
    int cyc, nonzero;
    bit clr;
    logic [7:0] th;
    for (int it = 0; it < 8; it++) begin
      int hi;
      hi = (it % 2 == 0) ? 3 : 255;
      for (int i = 0; i < WORDS; i++) img[i] = 8'($urandom_range(0, hi));
      th = 8'($urandom_range(0, hi));
      clr = 1'($urandom_range(0, 1));
      load_img(); clear_mon(); model(th);
      run_scan(clr, th, 1'b1, cyc);
      checks_total++;
      if (got.size() !== PIX || cyc < 0)
        $display("FAIL rand%0d_count got %0d results cyc=%0d, required %0d", it, got.size(), cyc, PIX);
      else checks_passed++;
      for (int p = 0; p < PIX; p++) begin
        res_t g;
        g = (p < got.size()) ? got[p] : '1;
        checks_total++;
        if (g !== exp_res[p]) $display("FAIL rand%0d_result[%0d] got %h, required %h", it, p, g, exp_res[p]);
        else checks_passed++;
      end
      nonzero = 0;
      for (int i = 0; i < WORDS; i++) if (mem[i] != (clr ? 8'd0 : img[i])) nonzero++;
      checks_total++;
      if (nonzero != 0) $display("FAIL rand%0d_ram got %0d wrong words (clear=%0d), required 0", it, nonzero, clr);
      else checks_passed++;
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_basic();
    test_tie();
    test_clear();
    test_back_pressure();
    test_start_ignored();
    test_reset_mid_scan();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
